// File: rtl/encoder_latch_scheduler.sv
// ---------------------------------------------------------------------------
// encoder_latch_scheduler
//
// Periodic sampling controller for a bank of quadrature decoders that share
// one latch strobe. An interval timer produces a sample tick every period+1
// clocks. Each tick fires a one-cycle latch pulse to all decoders. One cycle
// later the latched counters are snapshotted, and the snapshot is streamed
// out one word per channel. A tick that arrives while a frame is still in
// flight is dropped and recorded in the sticky overrun flag.
//
// Optional feature (macro ENC_SCHED_TIMESTAMP_EN):
//   adds out_timestamp, a free-running 32-bit clock count captured in the
//   LATCH cycle and held for every word of that frame.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous reset, active-low
//   enable         1 = run periodic sampling
//   period         sample interval minus one, in clk cycles
//   latch          common latch strobe to all decoders (1-cycle pulse)
//   counter_in     decoder counters, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid      output word valid
//   out_ready      consumer accepts word when out_valid && out_ready
//   out_channel    channel index of out_data
//   out_data       snapshot counter value
//   out_last       1 on the word of channel NUM_CHANNELS-1
//   overrun        sticky: a sample tick was dropped
//   overrun_clear  synchronous clear of overrun
//   out_timestamp  (ENC_SCHED_TIMESTAMP_EN only) frame timestamp
//   fsm_state      debug view of the frame FSM (0 IDLE,1 LATCH,2 CAPTURE,3 SEND)
//
// Output handshake: out_valid, out_channel, out_data and out_last are all
// functions of registered state only, so a word stays stable while
// out_ready=0; a word transfers on a cycle with out_valid && out_ready, and
// out_valid never drops without a transfer except on reset.
// ---------------------------------------------------------------------------
module encoder_latch_scheduler #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic [PERIOD_WIDTH-1:0]            period,
  output logic                               latch,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] counter_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(NUM_CHANNELS):0]      out_channel,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               out_last,
  output logic                               overrun,
  input  logic                               overrun_clear,
`ifdef ENC_SCHED_TIMESTAMP_EN
  output logic [31:0]                        out_timestamp,
`endif
  output logic [1:0]                         fsm_state
);

  localparam int CH_W = $clog2(NUM_CHANNELS) + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LATCH   = 2'd1,
    S_CAPTURE = 2'd2,
    S_SEND    = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CH_W-1:0]         ch;
  logic [CH_W-1:0]         ch_next;
  logic [PERIOD_WIDTH-1:0] timer;
  logic                    tick;
  logic                    ch_is_last;
  logic [DATA_WIDTH-1:0]   snap [NUM_CHANNELS];

  // -------------------------------------------------------------------------
  // Interval timer. While disabled it keeps reloading period so the first
  // tick after enable rises lands exactly period+1 cycles later. period is
  // only looked at on reload, so changing it mid-interval takes effect on
  // the following interval.
  // -------------------------------------------------------------------------
  assign tick = enable && (timer == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (!enable || (timer == '0)) begin
      timer <= period;
    end else begin
      timer <= timer - PERIOD_WIDTH'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Frame FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      ch    <= '0;
    end else begin
      state <= state_next;
      ch    <= ch_next;
    end
  end

  assign ch_is_last = (ch == LAST_CH);

  // -------------------------------------------------------------------------
  // Frame FSM: next state and channel pointer
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    ch_next    = ch;
    case (state)
      S_IDLE: begin
        if (tick) begin
          state_next = S_LATCH;
        end
      end
      S_LATCH: begin
        state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        ch_next    = '0;
        state_next = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          if (ch_is_last) begin
            state_next = S_IDLE;
          end else begin
            ch_next = ch + CH_W'(1);
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Snapshot buffer. Decoders register their counters on the LATCH edge, so
  // the values on counter_in during CAPTURE are the latched ones.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        snap[k] <= '0;
      end
    end else if (state == S_CAPTURE) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        snap[k] <= counter_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Overrun: any tick seen outside IDLE is dropped. Setting takes priority
  // over a coincident clear so a drop is never lost.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (tick && (state != S_IDLE)) begin
      overrun <= 1'b1;
    end else if (overrun_clear) begin
      overrun <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Output stream. The data mux compares ch against each constant index so
  // ch never needs to be narrowed to an array index.
  // -------------------------------------------------------------------------
  always_comb begin
    out_data = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (ch == CH_W'(k)) begin
        out_data = snap[k];
      end
    end
  end

  assign latch       = (state == S_LATCH);
  assign out_valid   = (state == S_SEND);
  assign out_channel = ch;
  assign out_last    = out_valid && ch_is_last;
  assign fsm_state   = state;

`ifdef ENC_SCHED_TIMESTAMP_EN
  // -------------------------------------------------------------------------
  // Frame timestamp: free-running clock count, captured in the LATCH cycle.
  // -------------------------------------------------------------------------
  logic [31:0] ts_count;
  logic [31:0] ts_frame;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_count <= '0;
      ts_frame <= '0;
    end else begin
      ts_count <= ts_count + 32'd1;
      if (state == S_LATCH) begin
        ts_frame <= ts_count;
      end
    end
  end

  assign out_timestamp = ts_frame;
`endif

endmodule

// File: tb/tb_encoder_latch_scheduler.sv
module tb_encoder_latch_scheduler;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] period;
  logic        latch;
  logic [63:0] counter_in;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_channel;
  logic [15:0] out_data;
  logic        out_last;
  logic        overrun;
  logic        overrun_clear;
  logic [1:0]  fsm_state;
`ifdef ENC_SCHED_TIMESTAMP_EN
  logic [31:0] out_timestamp;
`endif

  always #5 clk = ~clk;

  encoder_latch_scheduler dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .period        (period),
    .latch         (latch),
    .counter_in    (counter_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_channel   (out_channel),
    .out_data      (out_data),
    .out_last      (out_last),
    .overrun       (overrun),
    .overrun_clear (overrun_clear),
`ifdef ENC_SCHED_TIMESTAMP_EN
    .out_timestamp (out_timestamp),
`endif
    .fsm_state     (fsm_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  typedef struct {
    logic        en;
    logic        rdy;
    logic        clr;
    logic [63:0] cnt;
    logic        exp_latch;
    logic        exp_valid;
    logic [2:0]  exp_ch;
    logic        exp_last;
    logic [15:0] exp_data;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs[14];

  localparam logic [63:0] JUNK = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] CAPV = 64'h0004_FFFF_8000_0001;

  // -------------------------------------------------------------------------
  // Driver / checker tasks
  // -------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic en, input logic rdy, input logic clr,
                              input logic [63:0] cnt, input logic l, input logic v,
                              input logic [2:0] ch, input logic last,
                              input logic [15:0] data, input logic ovr);
    vec_t r;
    r.en = en; r.rdy = rdy; r.clr = clr; r.cnt = cnt;
    r.exp_latch = l; r.exp_valid = v; r.exp_ch = ch; r.exp_last = last;
    r.exp_data = data; r.exp_ovr = ovr;
    return r;
  endfunction

  // Wait (bounded) until the FSM is idle with no word pending.
  task automatic drain(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!out_valid && !latch && fsm_state == 2'd0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check(name, 64'(done), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  initial begin
    logic        found;
    int          n_latch;
    int          n_valid;
    int          first_latch;
    logic [31:0] e;

    reset_n       = 1'b0;
    enable        = 1'b0;
    period        = '0;
    counter_in    = '0;
    out_ready     = 1'b0;
    overrun_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_latch",   64'(latch),     64'd0);
    check("reset_valid",   64'(out_valid), 64'd0);
    check("reset_overrun", 64'(overrun),   64'd0);
    check("reset_data",    64'(out_data),  64'd0);
`ifdef ENC_SCHED_TIMESTAMP_EN
    check("reset_ts",      64'(out_timestamp), 64'd0);
`endif

    reset_n = 1'b1;
    period  = 16'd3;
    step();

    // ---- Table: period=3, full frame, snapshot isolation, dropped tick,
    //      overrun clear, next frame.
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, JUNK, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, JUNK, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0);
    vecs[2]  = mk(1'b1, 1'b1, 1'b0, JUNK, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0);
    vecs[3]  = mk(1'b1, 1'b1, 1'b0, JUNK, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, JUNK, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0);
    vecs[5]  = mk(1'b1, 1'b1, 1'b0, CAPV, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0);
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, JUNK, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0001, 1'b0);
    vecs[7]  = mk(1'b1, 1'b1, 1'b0, JUNK, 1'b0, 1'b1, 3'd1, 1'b0, 16'h8000, 1'b0);
    vecs[8]  = mk(1'b1, 1'b1, 1'b0, JUNK, 1'b0, 1'b1, 3'd2, 1'b0, 16'hFFFF, 1'b1);
    vecs[9]  = mk(1'b1, 1'b1, 1'b1, JUNK, 1'b0, 1'b1, 3'd3, 1'b1, 16'h0004, 1'b1);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, JUNK, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0);
    vecs[11] = mk(1'b1, 1'b1, 1'b0, JUNK, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0);
    vecs[12] = mk(1'b1, 1'b1, 1'b0, JUNK, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0);
    vecs[13] = mk(1'b1, 1'b1, 1'b0, JUNK, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0);

    for (int i = 0; i < 14; i++) begin
      enable        = vecs[i].en;
      out_ready     = vecs[i].rdy;
      overrun_clear = vecs[i].clr;
      counter_in    = vecs[i].cnt;
      #1;
      check($sformatf("tbl%0d_latch", i),   64'(latch),     64'(vecs[i].exp_latch));
      check($sformatf("tbl%0d_valid", i),   64'(out_valid), 64'(vecs[i].exp_valid));
      check($sformatf("tbl%0d_overrun", i), 64'(overrun),   64'(vecs[i].exp_ovr));
      if (vecs[i].exp_valid) begin
        check($sformatf("tbl%0d_ch", i),   64'(out_channel), 64'(vecs[i].exp_ch));
        check($sformatf("tbl%0d_last", i), 64'(out_last),    64'(vecs[i].exp_last));
        check($sformatf("tbl%0d_data", i), 64'(out_data),    64'(vecs[i].exp_data));
      end
      @(posedge clk);
      #1;
    end
    overrun_clear = 1'b0;

    // ---- Reset in the middle of SEND with out_ready=0.
    out_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("rst_mid_send_reached", 64'(found), 64'd1);
    #3;
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    check("rst_async_valid",   64'(out_valid),   64'd0);
    check("rst_async_latch",   64'(latch),       64'd0);
    check("rst_async_channel", 64'(out_channel), 64'd0);
    check("rst_async_data",    64'(out_data),    64'd0);
    check("rst_async_last",    64'(out_last),    64'd0);
    check("rst_async_overrun", 64'(overrun),     64'd0);
    check("rst_async_state",   64'(fsm_state),   64'd0);
    step();
    reset_n = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid || latch) n_valid++;
    end
    check("rst_no_words_after", 64'(n_valid), 64'd0);

    // ---- period=9: latch at 10, 20, 30; 4 words ch0..3 per frame.
    period    = 16'd9;
    out_ready = 1'b1;
    step();
    enable = 1'b1;
    exp_q.delete();
    got_q.delete();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(32'(k));
    end
    for (int c = 0; c < 37; c++) begin
      if (latch) got_q.push_back(32'(c));
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check($sformatf("p9_c%0d_ch", c),   64'(out_channel), 64'(e));
        check($sformatf("p9_c%0d_last", c), 64'(out_last),    64'(e == 32'd3));
      end
      step();
    end
    check("p9_words_left", 64'(exp_q.size()), 64'd0);
    check("p9_latch_count", 64'(got_q.size()), 64'd3);
    check("p9_latch0", 64'(got_q[0]), 64'd10);
    check("p9_latch1", 64'(got_q[1]), 64'd20);
    check("p9_latch2", 64'(got_q[2]), 64'd30);

    // ---- period=3 with out_ready held low: stall, drop, set-wins.
    enable        = 1'b0;
    out_ready     = 1'b0;
    overrun_clear = 1'b1;
    period        = 16'd3;
    drain("p3_idle_before");
    step();
    check("p3_overrun_cleared", 64'(overrun), 64'd0);
    overrun_clear = 1'b0;
    enable        = 1'b1;
    counter_in    = 64'h1111_2222_3333_4444;
    n_latch       = 0;
    for (int c = 0; c < 26; c++) begin
      overrun_clear = (c == 15) || (c == 17);
      if (c > 5) counter_in = 64'hFFFF_0000_FFFF_0000 ^ 64'(c);
      #1;
      if (latch) n_latch++;
      if (c >= 6) begin
        check($sformatf("stall_c%0d_valid", c), 64'(out_valid),   64'd1);
        check($sformatf("stall_c%0d_ch", c),    64'(out_channel), 64'd0);
        check($sformatf("stall_c%0d_data", c),  64'(out_data),    64'h4444);
      end
      if (c == 7)  check("stall_ovr_c7",  64'(overrun), 64'd0);
      if (c == 8)  check("stall_ovr_c8",  64'(overrun), 64'd1);
      if (c == 16) check("stall_ovr_set_wins", 64'(overrun), 64'd1);
      if (c == 18) check("stall_ovr_cleared",  64'(overrun), 64'd0);
      if (c == 20) check("stall_ovr_reset",    64'(overrun), 64'd1);
      @(posedge clk);
      #1;
    end
    overrun_clear = 1'b0;
    check("stall_single_latch", 64'(n_latch), 64'd1);
    out_ready = 1'b1;
    enable    = 1'b0;
    drain("stall_drain");

    // ---- enable falls during ch1: frame completes, then silence.
    period = 16'd9;
    step();
    enable = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid && out_channel == 3'd1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("en_fall_reached_ch1", 64'(found), 64'd1);
    enable = 1'b0;
    period = 16'd4;
    exp_q.delete();
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    n_latch = 0;
    for (int c = 0; c < 40; c++) begin
      if (latch) n_latch++;
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check($sformatf("en_fall_c%0d_ch", c),   64'(out_channel), 64'(e));
        check($sformatf("en_fall_c%0d_last", c), 64'(out_last),    64'(e == 32'd3));
      end
      step();
    end
    check("en_fall_words_left", 64'(exp_q.size()), 64'd0);
    check("en_fall_no_latch",   64'(n_latch),      64'd0);

    enable      = 1'b1;
    first_latch = -1;
    for (int c = 0; c < 9; c++) begin
      if (latch && first_latch < 0) first_latch = c;
      step();
    end
    check("reenable_p4_latch", 64'(first_latch), 64'd5);
    enable = 1'b0;
    drain("reenable_drain");

`ifdef ENC_SCHED_TIMESTAMP_EN
    // ---- Timestamp: 100 apart between frames, constant inside a frame.
    period = 16'd99;
    step();
    enable = 1'b1;
    got_q.delete();
    for (int c = 0; c < 251; c++) begin
      if (out_valid) begin
        if (out_channel == 3'd0) got_q.push_back(out_timestamp);
        else check($sformatf("ts_c%0d_hold", c), 64'(out_timestamp), 64'(got_q[$]));
      end
      step();
    end
    check("ts_frames", 64'(got_q.size()), 64'd2);
    check("ts_delta",  64'(got_q[1] - got_q[0]), 64'd100);
    enable = 1'b0;
    drain("ts_drain");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
